// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity-mode constants and vote helper for the UART receiver
package uart_pkg;

  // Receiver FSM states; encoding 3'd7 is unused and recovers to ST_IDLE
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Two-out-of-three vote used to reject single-cycle line glitches
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - two-flop line synchroniser with a three-sample majority window
module uart_bit_sampler
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_rx,
  output logic o_sync,
  output logic o_maj
);

  logic       r_meta;
  logic       r_sync;
  logic [1:0] r_hist;

  // Synchronise the asynchronous line and keep the two previous synchronised samples
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 2'b11;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_hist <= {r_hist[0], r_sync};
    end
  end

  assign o_sync = r_sync;
  // Vote covers the current synchronised sample and the two before it
  assign o_maj  = majority3(r_hist[1], r_hist[0], r_sync);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with parity, stop-bit and break handling
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 870,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 inputRx,
  output logic [DATA_BITS-1:0] outputRx,
  output logic                 doneRx,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 busyRx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic ODD_PARITY = (PARITY_MODE == PARITY_ODD);

  uart_state_t          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_work;
  logic                 r_frm_work;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_par_err;
  logic                 r_frm_err;

  logic w_sync;
  logic w_maj;

  uart_bit_sampler u_sampler (
    .i_clk  (clk),
    .i_rstn (rstN),
    .i_rx   (inputRx),
    .o_sync (w_sync),
    .o_maj  (w_maj)
  );

  // Frame FSM: bit timing, payload assembly, error tracking and result registers
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_work <= 1'b0;
      r_frm_work <= 1'b0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (!w_sync) begin
            r_state    <= ST_START;
            r_cnt      <= '0;
            r_par_work <= 1'b0;
            r_frm_work <= 1'b0;
          end
        end
        ST_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            // A high vote mid start bit means the falling edge was a glitch
            r_state <= w_maj ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            // LSB arrives first, so shift in from the top
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_par_work <= ((^r_shift) ^ w_maj) != ODD_PARITY;
            r_state    <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= ST_DONE;
              r_data    <= r_shift;
              r_par_err <= r_par_work;
              r_frm_err <= r_frm_work | ~w_maj;
              r_done    <= 1'b1;
            end else begin
              r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
              r_frm_work <= r_frm_work | ~w_maj;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // A framing error may be a break; wait for the line to recover first
          r_state <= r_frm_err ? ST_WAIT_IDLE : ST_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (w_sync) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign outputRx  = r_data;
  assign doneRx    = r_done;
  assign parityErr = HAS_PARITY ? r_par_err : 1'b0;
  assign frameErr  = r_frm_err;
  assign busyRx    = (r_state != ST_IDLE);

endmodule
